// File: rtl/wb_la_master.sv
// Single-outstanding Wishbone classic initiator: command in, one bus cycle, response out.
// Optional bus watchdog enabled by defining WB_LA_MASTER_TIMEOUT_EN.
module wb_la_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // Command side: a command is taken on the cycle cmd_valid_i && cmd_ready_o is
    // sampled high at a rising edge; the response is consumed on the cycle
    // rsp_valid_o && rsp_ready_i is sampled high; both producers hold until then.
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        timeout;

`ifdef WB_LA_MASTER_TIMEOUT_EN
    // Expiry fires on the TIMEOUT_CYCLES-th BUS cycle, so cyc is high that many cycles.
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        rsp_err_q, rsp_err_d;

    assign timeout = (state_q == S_BUS) && (cnt_q == TIMEOUT_LIM);

    always_comb begin
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (state_q == S_BUS) begin
            cnt_d = cnt_q + 16'd1;
            if (wbm_ack_i) begin
                rsp_err_d = 1'b0;
            end else if (timeout) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^{ERR_DATA, TIMEOUT_CYCLES};
    assign timeout    = 1'b0;
    assign rsp_err_o  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is checked first so a coincident expiry still completes normally.
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
                    state_d   = S_RESP;
                end else if (timeout) begin
                    cyc_d     = 1'b0;
`ifdef WB_LA_MASTER_TIMEOUT_EN
                    rsp_dat_d = ERR_DATA;
`endif
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE) && !wb_rst_i;
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: doc/wb_la_master.md
WB_LA_MASTER -- requirements
Module: wb_la_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: BUS-state cycles without ack before abort; legal range 1..65535.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: value returned on rsp_dat_o for an aborted cycle.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named wb_clk_i and wb_rst_i.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have command ports, all inputs except cmd_ready_o:
- cmd_valid_i, 1 bit
- cmd_ready_o, output, 1 bit
- cmd_we_i, 1 bit
- cmd_sel_i, 4 bits
- cmd_adr_i, 32 bits
- cmd_dat_i, 32 bits
REQ-007 SHALL have response ports, all outputs except rsp_ready_i:
- rsp_valid_o, 1 bit
- rsp_ready_i, input, 1 bit
- rsp_dat_o, 32 bits: read data
- rsp_err_o, 1 bit: timeout abort
REQ-008 SHALL have Wishbone initiator outputs: wbm_cyc_o 1, wbm_stb_o 1, wbm_we_o 1, wbm_sel_o 4, wbm_adr_o 32, wbm_dat_o 32.
REQ-009 SHALL have Wishbone initiator inputs: wbm_ack_i 1, wbm_dat_i 32.
REQ-010 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUS and RESP, and SHALL allow at most one outstanding transaction.
REQ-012 SHALL drive cmd_ready_o high only in IDLE.
REQ-013 SHALL, on the handshake cmd_valid_i && cmd_ready_o at edge N, register we/sel/adr/dat onto wbm_* and enter BUS, so that wbm_cyc_o and wbm_stb_o are high from cycle N+1.
REQ-014 SHALL hold wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o stable throughout BUS.
REQ-015 SHALL, in BUS, respond to wbm_ack_i sampled high at edge M as follows:
- clear cyc/stb at the same edge, so they are low at M+1
- capture wbm_dat_i into rsp_dat_o on a read; load 0 on a write
- clear rsp_err_o
- enter RESP
REQ-016 SHALL count BUS cycles with a 16-bit counter that is cleared on entry to BUS.
REQ-017 SHALL, when the counter reaches TIMEOUT_CYCLES with no ack, drop cyc/stb, load ERR_DATA into rsp_dat_o, set rsp_err_o and enter RESP.
REQ-018 SHALL give ack priority over timeout when both occur in the same cycle: normal completion, rsp_err_o=0.
REQ-019 SHALL assert rsp_valid_o throughout RESP, and hold rsp_dat_o and rsp_err_o stable until rsp_valid_o && rsp_ready_i.
REQ-020 SHALL return to IDLE on that handshake, with cmd_ready_o high the next cycle, giving a minimum of 3 cycles between accepted commands.
REQ-021 SHALL ignore wbm_ack_i in IDLE and RESP.
REQ-022 SHALL keep wbm_stb_o equal to wbm_cyc_o at all times; there are no bursts and no pipelined mode.

Reset
REQ-023 SHALL, while wb_rst_i is high at an edge, enter IDLE and clear the timeout counter.
REQ-024 SHALL reset these outputs to 0: wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_err_o, rsp_dat_o and busy_o; cmd_ready_o SHALL be 0 during reset.
REQ-025 SHALL, on reset in BUS or RESP, drop cyc/stb at that edge and discard the transaction with no response, accepting a new command from the first cycle after reset deasserts.

Configuration
REQ-026 SHALL provide macro WB_LA_MASTER_TIMEOUT_EN.
- Defined: the watchdog of REQ-016 to REQ-018 is present.
- Undefined: no counter is synthesized, BUS waits indefinitely for ack, rsp_err_o is tied 0, and ERR_DATA is unused.

Verification
REQ-027 SHALL check a write: cmd adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF, we=1 at edge 0.
- Response: cyc/stb high from cycle 1, adr/dat/sel/we matching.
- Ack at cycle 3: cyc low at 4, rsp_valid at 4, rsp_dat=0, err=0.
REQ-028 SHALL check a read: adr=0x3000_0000, we=0, sel=0x3, with ack and wbm_dat_i=0x1234_5678 at cycle 2.
- Response: rsp_dat_o=0x1234_5678 at cycle 3.
- rsp_ready_i held low 5 cycles: data stable; cmd_ready_o stays low.
REQ-029 SHALL check a timeout with TIMEOUT_CYCLES=4 and no ack.
- Response: cyc drops after 4 BUS cycles; rsp_err=1, rsp_dat=0xDEAD_BEEF.
- With the macro undefined: cyc stays high for 100 cycles.
REQ-030 SHALL check ack coincident with the expiry cycle (TIMEOUT_CYCLES=4, ack on the 4th BUS cycle) -> rsp_err=0, read data returned.
REQ-031 SHALL check reset asserted on the 2nd BUS cycle.
- Response: cyc/stb low next cycle; no rsp_valid.
- cmd_ready_o high on the first cycle after reset release; a stray ack then is ignored.
